loopback_rd_stage: RTL and testbench
====================================

Name: loopback_rd_stage

Overview:
Upstream feeder for the loopback FIFO. On start, it issues num_lines CCI-P cache-line read requests from base_addr. It pushes each 512-bit read response into the FIFO enqueue port one cycle after arrival. A credit counter, refilled by FIFO dequeues, bounds outstanding reads so the FIFO can never overflow.

Parameters:
DATA_WIDTH, 512, read-response/FIFO data width
ADDR_WIDTH, 42, cache-line address width
FIFO_DEPTH, 8, downstream FIFO depth; usable capacity = FIFO_DEPTH-1 = CREDITS
LEN_WIDTH, 32, width of num_lines and progress counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous reset, active-low (0 = reset asserted)
start  in  1  one-cycle pulse, sampled only in IDLE
base_addr  in  ADDR_WIDTH  first cache-line address, captured on start
num_lines  in  LEN_WIDTH  lines to transfer, captured on start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at completion
rd_req_valid  out  1  read request strobe, one per line
rd_req_addr  out  ADDR_WIDTH  request address
rd_req_almfull  in  1  shell back-pressure; no request issued while high
rd_rsp_valid  in  1  read response strobe; responses return in order
rd_rsp_data  in  DATA_WIDTH  response payload
enq_data  out  DATA_WIDTH  to FIFO enq_data
enq_en  out  1  to FIFO enq_en
not_full  in  1  from FIFO not_full
deq_fire  in  1  FIFO dequeue accepted (deq_en && not_empty); returns one credit
lines_issued  out  LEN_WIDTH  requests issued this run
lines_received  out  LEN_WIDTH  responses enqueued this run
error  out  1  sticky: overflow or response outside a run

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0; credits = CREDITS; counters 0; error 0.
- FSM states:
  - IDLE: start -> capture base_addr/num_lines, clear counters -> REQ. If num_lines==0 -> DONE instead.
  - REQ: issue condition = credits>0 && !rd_req_almfull && lines_issued<num_lines. When lines_issued reaches num_lines -> DRAIN.
  - DRAIN: wait until lines_received==num_lines -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- Requests:
  - Issue decision in cycle N registers rd_req_valid=1 and rd_req_addr=base_addr+lines_issued in cycle N+1; lines_issued increments at the same edge.
  - Issue rate is at most one per cycle, back-to-back allowed.
  - rd_req_valid is 0 on every non-issue cycle.
  - Address addition wraps modulo 2^ADDR_WIDTH.
- Credits (width $clog2(FIFO_DEPTH)+1):
  - Issue: -1. deq_fire: +1. Both in the same cycle: unchanged.
  - Never exceeds CREDITS; a deq_fire at CREDITS sets error and the counter saturates.
  - deq_fire is counted in every state, including IDLE (late drain of a previous run).
- Responses:
  - rd_rsp_valid in cycle N -> enq_en=1, enq_data=rd_rsp_data in cycle N+1, lines_received+1.
  - Response while not_full==0: still enqueued (FIFO drops it) and error=1.
  - Response in IDLE/DONE: dropped, error=1.
- busy = state in {REQ, DRAIN}, registered.
- error clears only on reset.
- Reset mid-run clears everything immediately. In-flight responses arriving after reset is released set error.

Decomposition:
- hc_pkg holds:
  - typedef t_cl_addr (ADDR_WIDTH), t_cl_data (DATA_WIDTH)
  - enum t_rd_state {RD_IDLE, RD_REQ, RD_DRAIN, RD_DONE}
  - constant LOOPBACK_CREDITS = FIFO_DEPTH-1
- One natural sub-module, loopback_credit_cnt: up/down saturating counter with overflow flag, reused by the write-side stage.

Test Plan:
- Reset then idle: base_addr=0x100, num_lines=4, start, FIFO dequeuing every cycle, responses 3 cycles after requests -> rd_req_addr 0x100..0x103 on consecutive cycles; 4 enq_en pulses with matching data; done pulse; lines_issued=lines_received=4; error=0.
- Credit stall: num_lines=20, no deq_fire -> exactly 7 requests issued, then rd_req_valid stays 0. Enable deq_fire one pulse -> exactly one more request next cycle.
- Back-pressure: hold rd_req_almfull=1 for 10 cycles mid-run -> no requests during the window; resume at the same address; final count=num_lines.
- Edge cases: num_lines=0 -> done pulses within 2 cycles, no requests. Base_addr=2^42-2, num_lines=3 -> addresses ...FFE, ...FFF, 0x0.
- Errors: response while IDLE -> error=1, enq_en stays 0. deq_fire with credits=7 -> error=1, credits remain 7.
- Async reset mid-run: assert reset between clock edges after 3 issues -> outputs 0 immediately, credits=7, state IDLE; a new start runs cleanly.

Source files
------------

// File: rtl/hc_pkg.sv
// Shared types and constants for the loopback read/write stages.
package hc_pkg;

   localparam int CL_DATA_WIDTH       = 512;
   localparam int CL_ADDR_WIDTH       = 42;
   localparam int CL_LEN_WIDTH        = 32;
   localparam int LOOPBACK_FIFO_DEPTH = 8;
   // One FIFO slot is kept unused, so the stage may only have DEPTH-1 lines in flight.
   localparam int LOOPBACK_CREDITS    = LOOPBACK_FIFO_DEPTH - 1;

   typedef logic [CL_ADDR_WIDTH-1:0] t_cl_addr;
   typedef logic [CL_DATA_WIDTH-1:0] t_cl_data;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_REQ   = 2'd1,
      RD_DRAIN = 2'd2,
      RD_DONE  = 2'd3
   } t_rd_state;

endpackage

// File: rtl/loopback_rd_stage_if.sv
// Read-request, read-response and FIFO-enqueue signals of the loopback read stage.
interface loopback_rd_stage_if #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDR_WIDTH = 42
);
   logic                  rd_req_valid;
   logic [ADDR_WIDTH-1:0] rd_req_addr;
   logic                  rd_req_almfull;
   logic                  rd_rsp_valid;
   logic [DATA_WIDTH-1:0] rd_rsp_data;
   logic [DATA_WIDTH-1:0] enq_data;
   logic                  enq_en;
   logic                  not_full;
   logic                  deq_fire;

   // Stage side: drives requests and FIFO writes.
   modport master (
      output rd_req_valid, rd_req_addr, enq_data, enq_en,
      input  rd_req_almfull, rd_rsp_valid, rd_rsp_data, not_full, deq_fire
   );

   // Shell/FIFO side: the mirror image.
   modport slave (
      input  rd_req_valid, rd_req_addr, enq_data, enq_en,
      output rd_req_almfull, rd_rsp_valid, rd_rsp_data, not_full, deq_fire
   );
endinterface

// File: rtl/loopback_credit_cnt.sv
// Up/down saturating credit counter; resets full, flags a return while already full.
module loopback_credit_cnt #(
   parameter int WIDTH = 4,
   parameter int MAX   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o,
   output logic             ovf_o
);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Next count: simultaneous inc/dec cancel, both directions saturate.
   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (inc_i && !dec_i) begin
         if (count_q == MAX_C) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + ONE_C;
         end
      end else if (dec_i && !inc_i) begin
         if (count_q != ZERO_C) begin
            count_d = count_q - ONE_C;
         end else begin
            count_d = count_q;
         end
      end else begin
         count_d = count_q;
      end
   end

   // Counter and overflow strobe registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= MAX_C;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count_o = count_q;
   assign ovf_o   = ovf_q;
endmodule

// File: rtl/loopback_rd_stage.sv
// Loopback read stage: issues cache-line reads and pushes responses into the FIFO,
// with outstanding reads bounded by FIFO credits.
module loopback_rd_stage
   import hc_pkg::*;
#(
   parameter int DATA_WIDTH = CL_DATA_WIDTH,
   parameter int ADDR_WIDTH = CL_ADDR_WIDTH,
   parameter int FIFO_DEPTH = LOOPBACK_FIFO_DEPTH,
   parameter int LEN_WIDTH  = CL_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  num_lines,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  lines_issued,
   output logic [LEN_WIDTH-1:0]  lines_received,
   output logic                  error,
   loopback_rd_stage_if.master   bus
);
   localparam int                   CREDIT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

   t_rd_state             state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]  num_q;
   logic [LEN_WIDTH-1:0]  lines_issued_q;
   logic [LEN_WIDTH-1:0]  lines_received_q;
   logic                  busy_q, done_q, error_q;
   logic                  rd_req_valid_q;
   logic [ADDR_WIDTH-1:0] rd_req_addr_q;
   logic                  enq_en_q;
   logic [DATA_WIDTH-1:0] enq_data_q;

   logic [CREDIT_W-1:0]   credits_s;
   logic                  ovf_s;
   logic                  issue_s;
   logic                  in_run_s;
   logic                  err_set_s;

   loopback_credit_cnt #(
      .WIDTH (CREDIT_W),
      .MAX   (FIFO_DEPTH - 1)
   ) u_credit (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (bus.deq_fire),
      .dec_i   (issue_s),
      .count_o (credits_s),
      .ovf_o   (ovf_s)
   );

   // Issue a request when in REQ with a credit, no back-pressure and lines left.
   always_comb begin
      if ((state_q == RD_REQ) && (credits_s != {CREDIT_W{1'b0}}) &&
          !bus.rd_req_almfull && (lines_issued_q < num_q)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Error sources: credit overflow, response outside a run, response into a full FIFO.
   always_comb begin
      in_run_s  = (state_q == RD_REQ) || (state_q == RD_DRAIN);
      err_set_s = ovf_s;
      if (bus.rd_rsp_valid) begin
         if (in_run_s) begin
            err_set_s = ovf_s | !bus.not_full;
         end else begin
            err_set_s = 1'b1;
         end
      end else begin
         err_set_s = ovf_s;
      end
   end

   // Control FSM with registered request, enqueue and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= RD_IDLE;
         base_q           <= {ADDR_WIDTH{1'b0}};
         num_q            <= LEN_ZERO;
         lines_issued_q   <= LEN_ZERO;
         lines_received_q <= LEN_ZERO;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         error_q          <= 1'b0;
         rd_req_valid_q   <= 1'b0;
         rd_req_addr_q    <= {ADDR_WIDTH{1'b0}};
         enq_en_q         <= 1'b0;
         enq_data_q       <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_req_valid_q <= 1'b0;
         enq_en_q       <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= error_q | err_set_s;

         case (state_q)
            RD_IDLE: begin
               if (start) begin
                  base_q           <= base_addr;
                  num_q            <= num_lines;
                  lines_issued_q   <= LEN_ZERO;
                  lines_received_q <= LEN_ZERO;
                  if (num_lines == LEN_ZERO) begin
                     state_q <= RD_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RD_REQ;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RD_REQ: begin
               if (issue_s) begin
                  rd_req_valid_q <= 1'b1;
                  rd_req_addr_q  <= base_q + ADDR_WIDTH'(lines_issued_q);
                  lines_issued_q <= lines_issued_q + LEN_ONE;
                  if ((lines_issued_q + LEN_ONE) == num_q) begin
                     state_q <= RD_DRAIN;
                  end
               end else if (lines_issued_q >= num_q) begin
                  state_q <= RD_DRAIN;
               end
            end
            RD_DRAIN: begin
               if (lines_received_q == num_q) begin
                  state_q <= RD_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            RD_DONE: begin
               state_q <= RD_IDLE;
            end
            default: begin
               state_q <= RD_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         // Responses during a run are forwarded one cycle later; the FIFO drops them if full.
         if (bus.rd_rsp_valid && in_run_s) begin
            enq_en_q         <= 1'b1;
            enq_data_q       <= bus.rd_rsp_data;
            lines_received_q <= lines_received_q + LEN_ONE;
         end
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign lines_issued     = lines_issued_q;
   assign lines_received   = lines_received_q;
   assign bus.rd_req_valid = rd_req_valid_q;
   assign bus.rd_req_addr  = rd_req_addr_q;
   assign bus.enq_en       = enq_en_q;
   assign bus.enq_data     = enq_data_q;
endmodule

// File: tb/tb_loopback_rd_stage.sv
// Directed bench for loopback_rd_stage with a small shell/FIFO model.
module tb_loopback_rd_stage;
   import hc_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [41:0] base_addr = 42'h0;
   logic [31:0] num_lines = 32'h0;
   logic        busy, done, error;
   logic [31:0] lines_issued, lines_received;

   loopback_rd_stage_if #(.DATA_WIDTH(512), .ADDR_WIDTH(42)) bus ();

   loopback_rd_stage dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .num_lines      (num_lines),
      .busy           (busy),
      .done           (done),
      .lines_issued   (lines_issued),
      .lines_received (lines_received),
      .error          (error),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   int  checks = 0;
   int  passed = 0;

   // knobs written only by the test sequence
   bit  rsp_en = 1'b0;
   bit  auto_deq = 1'b0;
   bit  man_deq = 1'b0;
   bit  man_rsp = 1'b0;

   // model state written only by the shell process
   int  cyc = 0;
   int  fifo_cnt = 0;
   bit  pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;
   logic [41:0]  pa0 = 42'h0, pa1 = 42'h0, pa2 = 42'h0;
   logic [41:0]  req_addr_q[$];
   int           req_cyc_q[$];
   logic [511:0] enq_data_q[$];
   int           enq_cyc_q[$];
   int           rsp_cyc_q[$];

   function automatic logic [511:0] pat(input logic [41:0] a);
      pat = {16{a[31:0] ^ 32'hC0DE_0000}};
   endfunction

   // Shell + FIFO model: logs requests/enqueues, returns in-order responses, dequeues.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!reset) begin
         pv0 = 1'b0; pv1 = 1'b0; pv2 = 1'b0;
         fifo_cnt = 0;
         bus.rd_rsp_valid = 1'b0;
         bus.rd_rsp_data  = 512'h0;
         bus.deq_fire     = 1'b0;
      end else begin
         if (bus.rd_req_valid === 1'b1) begin
            req_addr_q.push_back(bus.rd_req_addr);
            req_cyc_q.push_back(cyc);
         end
         if (bus.enq_en === 1'b1) begin
            enq_data_q.push_back(bus.enq_data);
            enq_cyc_q.push_back(cyc);
            fifo_cnt = fifo_cnt + 1;
         end
         bus.rd_rsp_valid = pv2 | man_rsp;
         bus.rd_rsp_data  = man_rsp ? {16{32'hDEAD_BEEF}} : pat(pa2);
         if (pv2) rsp_cyc_q.push_back(cyc);
         pv2 = pv1; pa2 = pa1;
         pv1 = pv0; pa1 = pa0;
         pv0 = rsp_en && (bus.rd_req_valid === 1'b1);
         pa0 = bus.rd_req_addr;
         bus.deq_fire = auto_deq ? (fifo_cnt > 0) : man_deq;
         if (bus.deq_fire && fifo_cnt > 0) fifo_cnt = fifo_cnt - 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_run(input logic [41:0] b, input logic [31:0] n);
      start = 1'b1; base_addr = b; num_lines = n;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick(1);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      bus.rd_req_almfull = 1'b0;
      bus.not_full = 1'b1;
      reset = 1'b0;
      tick(3);
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else passed++;
      checks++; if (bus.rd_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %0b want 0", bus.rd_req_valid); else passed++;
      checks++; if (bus.enq_en !== 1'b0) $display("FAIL rst_enq_en: got %0b want 0", bus.enq_en); else passed++;
      checks++; if (lines_issued !== 32'd0) $display("FAIL rst_issued: got %0d want 0", lines_issued); else passed++;
      checks++; if (error !== 1'b0) $display("FAIL rst_error: got %0b want 0", error); else passed++;
      reset = 1'b1;
      tick(2);
      checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b want 0", busy); else passed++;
   endtask

   task automatic test_basic();
      int rb, eb, sb, bad;
      bit ok;
      rb = req_addr_q.size(); eb = enq_data_q.size(); sb = rsp_cyc_q.size();
      rsp_en = 1'b1; auto_deq = 1'b1;
      start_run(42'h100, 32'd4);
      checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy); else passed++;
      wait_done(100, ok);
      checks++; if (ok !== 1'b1) $display("FAIL basic_done: got %0b want 1", ok); else passed++;
      checks++; if (lines_issued !== 32'd4) $display("FAIL basic_issued: got %0d want 4", lines_issued); else passed++;
      checks++; if (lines_received !== 32'd4) $display("FAIL basic_received: got %0d want 4", lines_received); else passed++;
      checks++; if (error !== 1'b0) $display("FAIL basic_error: got %0b want 0", error); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %0b want 0", busy); else passed++;
      tick(1);
      checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %0b want 0", done); else passed++;
      checks++; if (req_addr_q.size() - rb !== 4) $display("FAIL basic_req_count: got %0d want 4", req_addr_q.size() - rb); else passed++;
      bad = 0;
      if (req_addr_q.size() >= rb + 4) begin
         for (int i = 0; i < 4; i++) begin
            if (req_addr_q[rb+i] !== 42'h100 + 42'(i)) bad++;
            if (req_cyc_q[rb+i] !== req_cyc_q[rb] + i) bad++;
         end
      end else bad = 99;
      checks++; if (bad !== 0) $display("FAIL basic_req_seq: got %0d bad want 0", bad); else passed++;
      bad = 0;
      if (enq_data_q.size() >= eb + 4 && rsp_cyc_q.size() >= sb + 4) begin
         for (int i = 0; i < 4; i++) begin
            if (enq_data_q[eb+i] !== pat(42'h100 + 42'(i))) bad++;
            if (enq_cyc_q[eb+i] !== rsp_cyc_q[sb+i] + 1) bad++;
         end
      end else bad = 99;
      checks++; if (bad !== 0) $display("FAIL basic_enq_seq: got %0d bad want 0", bad); else passed++;
      tick(3);
   endtask

   task automatic test_credit_stall();
      int rb, bad;
      bit ok;
      rb = req_addr_q.size();
      rsp_en = 1'b1; auto_deq = 1'b0; man_deq = 1'b0;
      start_run(42'h2000, 32'd20);
      tick(30);
      checks++; if (req_addr_q.size() - rb !== 7) $display("FAIL stall_count: got %0d want 7", req_addr_q.size() - rb); else passed++;
      checks++; if (bus.rd_req_valid !== 1'b0) $display("FAIL stall_valid: got %0b want 0", bus.rd_req_valid); else passed++;
      man_deq = 1'b1;
      tick(1);
      man_deq = 1'b0;
      tick(1);
      checks++; if (bus.rd_req_valid !== 1'b1) $display("FAIL stall_refill_valid: got %0b want 1", bus.rd_req_valid); else passed++;
      checks++; if (bus.rd_req_addr !== 42'h2007) $display("FAIL stall_refill_addr: got %0h want 2007", bus.rd_req_addr); else passed++;
      tick(1);
      checks++; if (bus.rd_req_valid !== 1'b0) $display("FAIL stall_single: got %0b want 0", bus.rd_req_valid); else passed++;
      auto_deq = 1'b1;
      wait_done(400, ok);
      checks++; if (ok !== 1'b1) $display("FAIL stall_done: got %0b want 1", ok); else passed++;
      checks++; if (lines_received !== 32'd20) $display("FAIL stall_received: got %0d want 20", lines_received); else passed++;
      bad = 0;
      if (req_addr_q.size() == rb + 20) begin
         for (int i = 0; i < 20; i++) if (req_addr_q[rb+i] !== 42'h2000 + 42'(i)) bad++;
      end else bad = 99;
      checks++; if (bad !== 0) $display("FAIL stall_seq: got %0d bad want 0", bad); else passed++;
      checks++; if (error !== 1'b0) $display("FAIL stall_error: got %0b want 0", error); else passed++;
      tick(3);
   endtask

   task automatic test_backpressure();
      int rb, bad;
      bit ok;
      rb = req_addr_q.size();
      rsp_en = 1'b1; auto_deq = 1'b1;
      start_run(42'h3000, 32'd12);
      tick(2);
      bus.rd_req_almfull = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (bus.rd_req_valid !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL bp_window: got %0d requests want 0", bad); else passed++;
      checks++; if (lines_issued !== 32'd2) $display("FAIL bp_issued: got %0d want 2", lines_issued); else passed++;
      bus.rd_req_almfull = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bus.rd_req_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (ok !== 1'b1) $display("FAIL bp_resume: got %0b want 1", ok); else passed++;
      checks++; if (bus.rd_req_addr !== 42'h3002) $display("FAIL bp_resume_addr: got %0h want 3002", bus.rd_req_addr); else passed++;
      wait_done(200, ok);
      checks++; if (lines_issued !== 32'd12) $display("FAIL bp_final: got %0d want 12", lines_issued); else passed++;
      tick(3);
   endtask

   task automatic test_edges();
      int rb;
      bit ok;
      bit seen;
      rb = req_addr_q.size();
      start_run(42'h500, 32'd0);
      seen = (done === 1'b1);
      if (!seen) begin
         tick(1);
         seen = (done === 1'b1);
      end
      checks++; if (seen !== 1'b1) $display("FAIL zero_done: got %0b want 1", seen); else passed++;
      tick(4);
      checks++; if (req_addr_q.size() - rb !== 0) $display("FAIL zero_reqs: got %0d want 0", req_addr_q.size() - rb); else passed++;
      rb = req_addr_q.size();
      rsp_en = 1'b1; auto_deq = 1'b1;
      start_run(42'h3FF_FFFF_FFFE, 32'd3);
      wait_done(100, ok);
      checks++; if (ok !== 1'b1) $display("FAIL wrap_done: got %0b want 1", ok); else passed++;
      if (req_addr_q.size() == rb + 3) begin
         checks++; if (req_addr_q[rb] !== 42'h3FF_FFFF_FFFE) $display("FAIL wrap_a0: got %0h want 3fffffffffe", req_addr_q[rb]); else passed++;
         checks++; if (req_addr_q[rb+1] !== 42'h3FF_FFFF_FFFF) $display("FAIL wrap_a1: got %0h want 3ffffffffff", req_addr_q[rb+1]); else passed++;
         checks++; if (req_addr_q[rb+2] !== 42'h0) $display("FAIL wrap_a2: got %0h want 0", req_addr_q[rb+2]); else passed++;
      end else begin
         checks++; $display("FAIL wrap_count: got %0d want 3", req_addr_q.size() - rb);
      end
      tick(3);
   endtask

   task automatic test_errors();
      int eb;
      bit ok;
      apply_reset();
      eb = enq_data_q.size();
      rsp_en = 1'b1; auto_deq = 1'b1;
      bus.not_full = 1'b0;
      start_run(42'h700, 32'd2);
      wait_done(100, ok);
      bus.not_full = 1'b1;
      checks++; if (enq_data_q.size() - eb !== 2) $display("FAIL full_enq: got %0d want 2", enq_data_q.size() - eb); else passed++;
      checks++; if (error !== 1'b1) $display("FAIL full_error: got %0b want 1", error); else passed++;
      apply_reset();
      checks++; if (error !== 1'b0) $display("FAIL err_cleared: got %0b want 0", error); else passed++;
      man_rsp = 1'b1;
      tick(1);
      man_rsp = 1'b0;
      checks++; if (error !== 1'b1) $display("FAIL idle_rsp_error: got %0b want 1", error); else passed++;
      checks++; if (bus.enq_en !== 1'b0) $display("FAIL idle_rsp_enq: got %0b want 0", bus.enq_en); else passed++;
      tick(1);
      checks++; if (bus.enq_en !== 1'b0) $display("FAIL idle_rsp_enq2: got %0b want 0", bus.enq_en); else passed++;
      apply_reset();
      rsp_en = 1'b0; auto_deq = 1'b0;
      man_deq = 1'b1;
      tick(1);
      man_deq = 1'b0;
      tick(3);
      checks++; if (error !== 1'b1) $display("FAIL ovf_error: got %0b want 1", error); else passed++;
      eb = req_addr_q.size();
      start_run(42'h800, 32'd20);
      tick(20);
      checks++; if (req_addr_q.size() - eb !== 7) $display("FAIL ovf_credits: got %0d requests want 7", req_addr_q.size() - eb); else passed++;
   endtask

   task automatic test_async_reset();
      int rb;
      bit ok;
      apply_reset();
      rsp_en = 1'b0; auto_deq = 1'b0;
      start_run(42'h900, 32'd10);
      tick(3);
      checks++; if (lines_issued !== 32'd3) $display("FAIL ar_pre_issued: got %0d want 3", lines_issued); else passed++;
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.rd_req_valid !== 1'b0) $display("FAIL ar_valid: got %0b want 0", bus.rd_req_valid); else passed++;
      checks++; if (bus.rd_req_addr !== 42'h0) $display("FAIL ar_addr: got %0h want 0", bus.rd_req_addr); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL ar_busy: got %0b want 0", busy); else passed++;
      checks++; if (lines_issued !== 32'd0) $display("FAIL ar_issued: got %0d want 0", lines_issued); else passed++;
      #2 reset = 1'b1;
      tick(1);
      rb = req_addr_q.size();
      rsp_en = 1'b1;
      start_run(42'hA00, 32'd8);
      tick(20);
      checks++; if (req_addr_q.size() - rb !== 7) $display("FAIL ar_credits: got %0d requests want 7", req_addr_q.size() - rb); else passed++;
      auto_deq = 1'b1;
      wait_done(200, ok);
      checks++; if (ok !== 1'b1) $display("FAIL ar_done: got %0b want 1", ok); else passed++;
      checks++; if (lines_received !== 32'd8) $display("FAIL ar_received: got %0d want 8", lines_received); else passed++;
      checks++; if (error !== 1'b0) $display("FAIL ar_error: got %0b want 0", error); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_credit_stall();
      test_backpressure();
      test_edges();
      test_errors();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, %0d/%0d checks so far", passed, checks);
      $fatal(1);
   end
endmodule
